// File: rtl/whirlpool_round_sequencer.sv
// Whirlpool round sequencer.
// Collects eight 64-bit state rows, hands the assembled 512-bit block to an
// external round datapath, runs ROUNDS round-enable cycles, captures the
// datapath result and streams it back out one row at a time.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  row input handshake, in_row is one 64-bit row
//   dp_block        assembled state, row r column c byte at [64r+8c +: 8]
//   dp_load         one-cycle pulse, datapath loads dp_block
//   dp_round_en     datapath executes one round this cycle
//   dp_round_idx    round number 1..ROUNDS while dp_round_en, else 0
//   dp_result       datapath state, same byte mapping as dp_block
//   out_valid/ready result row handshake, out_row is one 64-bit row
//   busy            low only while collecting input rows
module whirlpool_round_sequencer #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_row,
  output logic [0:511] dp_block,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic [3:0]   dp_round_idx,
  input  logic [0:511] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_row,
  output logic         busy
);

  localparam logic [3:0] LastRound = 4'(ROUNDS);

  typedef enum logic [2:0] {
    StCollect,
    StLoad,
    StRound,
    StCapture,
    StDrain
  } state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [2:0]   r_row_cnt;
  logic [2:0]   r_out_cnt;
  logic [3:0]   r_round_cnt;
  logic [0:511] r_slots;
  logic [0:511] r_obuf;
  logic         w_in_hs;
  logic         w_out_hs;

  // Row slots feed the datapath directly; they only change while collecting,
  // so dp_block is stable from LOAD through CAPTURE.
  assign dp_block = r_slots;
  assign out_row  = r_obuf[{r_out_cnt, 6'd0} +: 64];

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    dp_load      = 1'b0;
    dp_round_en  = 1'b0;
    dp_round_idx = 4'd0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    w_in_hs      = 1'b0;
    w_out_hs     = 1'b0;
    case (r_state)
      StCollect: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_in_hs  = in_valid;
        if (in_valid && (r_row_cnt == 3'd7)) begin
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        dp_load      = 1'b1;
        w_state_next = StRound;
      end
      StRound: begin
        dp_round_en  = 1'b1;
        dp_round_idx = r_round_cnt;
        if (r_round_cnt == LastRound) begin
          w_state_next = StCapture;
        end
      end
      StCapture: begin
        w_state_next = StDrain;
      end
      StDrain: begin
        out_valid = 1'b1;
        w_out_hs  = out_ready;
        if (out_ready && (r_out_cnt == 3'd7)) begin
          w_state_next = StCollect;
        end
      end
      default: begin
        w_state_next = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StCollect;
      r_row_cnt   <= 3'd0;
      r_out_cnt   <= 3'd0;
      r_round_cnt <= 4'd0;
      r_slots     <= '0;
      r_obuf      <= '0;
    end else begin
      r_state <= w_state_next;
      // Counters are 3 bits wide, so the 8th handshake wraps them to 0.
      if (w_in_hs) begin
        r_slots[{r_row_cnt, 6'd0} +: 64] <= in_row;
        r_row_cnt                        <= r_row_cnt + 3'd1;
      end
      if (r_state == StLoad) begin
        r_round_cnt <= 4'd1;
      end else if (r_state == StRound) begin
        r_round_cnt <= (r_round_cnt == LastRound) ? 4'd0 : r_round_cnt + 4'd1;
      end
      if (r_state == StCapture) begin
        r_obuf <= dp_result;
      end
      if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_whirlpool_round_sequencer.sv
// Self-checking bench for whirlpool_round_sequencer: a scoreboard-style
// monitor compares the default build against a block-level reference model;
// a second ROUNDS=1 instance is checked with a short directed sequence.
module tb_whirlpool_round_sequencer;

  localparam int unsigned ROUNDS = 10;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RoundMask = (ROUNDS % 2 == 1) ? Ones : 64'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_row = '0;
  logic [0:511] dp_block;
  logic         dp_load;
  logic         dp_round_en;
  logic [3:0]   dp_round_idx;
  logic [0:511] dp_result = '0;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_row;
  logic         busy;

  logic         in_valid_b = 1'b0;
  logic         in_ready_b;
  logic [63:0]  in_row_b = '0;
  logic [0:511] dp_block_b;
  logic         dp_load_b;
  logic         dp_round_en_b;
  logic [3:0]   dp_round_idx_b;
  logic [0:511] dp_result_b = '0;
  logic         out_valid_b;
  logic         out_ready_b = 1'b1;
  logic [63:0]  out_row_b;
  logic         busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // out_ready source: 0 = always ready, 1 = random, 2 = driven by stimulus.
  int   out_mode = 0;
  logic rnd_ready = 1'b1;
  logic or_force = 1'b1;
  assign out_ready = (out_mode == 1) ? rnd_ready : (out_mode == 2) ? or_force : 1'b1;
  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 2) != 0);
  end

  whirlpool_round_sequencer #(.ROUNDS(ROUNDS)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .dp_block     (dp_block),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .dp_round_idx (dp_round_idx),
    .dp_result    (dp_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .busy         (busy)
  );

  whirlpool_round_sequencer #(.ROUNDS(1)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid_b),
    .in_ready     (in_ready_b),
    .in_row       (in_row_b),
    .dp_block     (dp_block_b),
    .dp_load      (dp_load_b),
    .dp_round_en  (dp_round_en_b),
    .dp_round_idx (dp_round_idx_b),
    .dp_result    (dp_result_b),
    .out_valid    (out_valid_b),
    .out_ready    (out_ready_b),
    .out_row      (out_row_b),
    .busy         (busy_b)
  );

  // Datapath models: load the block, then invert every byte once per round.
  always @(posedge clk) begin
    if (dp_load) dp_result <= dp_block;
    else if (dp_round_en) dp_result <= dp_result ^ {8{Ones}};
    if (dp_load_b) dp_result_b <= dp_block_b;
    else if (dp_round_en_b) dp_result_b <= dp_result_b ^ {8{Ones}};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_blk(input string name, input logic [0:511] act, input logic [0:511] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model and monitor ----------------
  logic [63:0]  m_part[$];
  logic [63:0]  exp_q[$];
  logic [0:511] m_blk = '0;
  int           cyc = 0;
  int           t8 = -1;
  bit           m_acc = 1'b1;
  bit           prev_rst = 1'b0;
  bit           prev_stall = 1'b0;
  logic [63:0]  prev_row = '0;
  int           n_out = 0;

  always @(negedge clk) begin
    int          d;
    bit          en_exp;
    bit          drain;
    logic [63:0] rw;
    logic [63:0] e;
    cyc++;
    if (prev_rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_dp_load", 64'(dp_load), 64'd0);
      chk("rst_round_en", 64'(dp_round_en), 64'd0);
      chk("rst_round_idx", 64'(dp_round_idx), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_row", out_row, 64'd0);
      chk_blk("rst_dp_block", dp_block, '0);
    end
    if (rst) begin
      m_part.delete();
      exp_q.delete();
      t8         = -1;
      m_acc      = 1'b1;
      n_out      = 0;
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      prev_rst = 1'b0;
      d        = (t8 >= 0) ? cyc - t8 : 0;
      en_exp   = (t8 >= 0) && (d >= 2) && (d <= 1 + ROUNDS);
      drain    = (t8 >= 0) && (d >= 3 + ROUNDS);
      chk("in_ready", 64'(in_ready), 64'(m_acc));
      chk("busy", 64'(busy), 64'(!m_acc));
      chk("dp_load", 64'(dp_load), 64'((t8 >= 0) && (d == 1)));
      chk("dp_round_en", 64'(dp_round_en), 64'(en_exp));
      chk("dp_round_idx", 64'(dp_round_idx), en_exp ? 64'(d - 1) : 64'd0);
      chk("out_valid", 64'(out_valid), 64'(drain));
      if ((t8 >= 0) && (d >= 1) && (d <= 2 + ROUNDS)) chk_blk("dp_block", dp_block, m_blk);
      if (prev_stall) chk("out_row_hold", out_row, prev_row);
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
      if (in_valid && m_acc) begin
        m_part.push_back(in_row);
        if (m_part.size() == 8) begin
          for (int r = 0; r < 8; r++) begin
            rw = m_part[r];
            for (int c = 0; c < 8; c++) m_blk[64*r+8*c +: 8] = rw[63-8*c -: 8];
            exp_q.push_back(rw ^ RoundMask);
          end
          m_part.delete();
          t8    = cyc;
          m_acc = 1'b0;
        end
      end
      if (drain && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_0000_0000_DEAD;
        chk("out_row", out_row, e);
        n_out++;
        if (n_out == 8) begin
          n_out = 0;
          t8    = -1;
          m_acc = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] blk[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [63:0] row, input bit gaps);
    int n = 0;
    bit hs = 1'b0;
    while (!hs && n < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_row   = in_valid ? row : {$urandom, $urandom};
      hs       = in_valid && in_ready;
      step();
      n++;
    end
    if (!hs) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_row: in_ready got %0b for 200 cycles, expected 1", in_ready);
    end
  endtask

  task automatic send_block(input bit gaps);
    for (int i = 0; i < 8; i++) send_row(blk[i], gaps);
  endtask

  task automatic rand_block();
    for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 500) begin
      step();
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: in_ready got 0 after 500 cycles, expected 1");
    end
  endtask

  initial begin
    int n;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic flow with the reference row pattern.
    for (int r = 0; r < 8; r++) blk[r] = 64'h0001_0203_0405_0607 + 64'h0808_0808_0808_0808 * 64'(r);
    send_block(1'b0);
    in_valid = 1'b0;
    chk("basic_dp_load", 64'(dp_load), 64'd1);
    chk("basic_byte_first", 64'(dp_block[0:7]), 64'h00);
    chk("basic_byte_last", 64'(dp_block[504:511]), 64'h3F);
    wait_idle();

    // Partial block discarded by reset.
    for (int i = 0; i < 3; i++) send_row({$urandom, $urandom}, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rand_block();
    send_block(1'b1);
    in_valid = 1'b0;
    wait_idle();

    // Random blocks with input gaps and random backpressure.
    out_mode = 1;
    for (int k = 0; k < 6; k++) begin
      rand_block();
      send_block(1'b1);
      in_valid = 1'b0;
      wait_idle();
    end

    // Five-cycle stall at row 3.
    out_mode = 2;
    or_force = 1'b1;
    rand_block();
    send_block(1'b0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    or_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    or_force = 1'b1;
    wait_idle();
    out_mode = 0;

    // Back-to-back blocks; in_valid stays high through ROUND and DRAIN.
    for (int k = 0; k < 3; k++) begin
      rand_block();
      send_block(1'b0);
    end
    in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of the round sequence, then a fresh block.
    rand_block();
    send_block(1'b0);
    in_valid = 1'b0;
    n = 0;
    while (dp_round_idx != 4'd4 && n < 50) begin
      step();
      n++;
    end
    chk("midrst_idx_reached", 64'(dp_round_idx), 64'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rand_block();
    send_block(1'b1);
    in_valid = 1'b0;
    wait_idle();

    // ROUNDS=1 instance: one round, first out_valid four cycles after the 8th row.
    rand_block();
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1'b1;
      in_row_b   = blk[i];
      chk("b_in_ready", 64'(in_ready_b), 64'd1);
      step();
    end
    in_valid_b = 1'b0;
    chk("b_dp_load", 64'(dp_load_b), 64'd1);
    chk("b_busy", 64'(busy_b), 64'd1);
    chk("b_en_at_load", 64'(dp_round_en_b), 64'd0);
    step();
    chk("b_round_en", 64'(dp_round_en_b), 64'd1);
    chk("b_round_idx", 64'(dp_round_idx_b), 64'd1);
    step();
    chk("b_en_after", 64'(dp_round_en_b), 64'd0);
    chk("b_valid_capture", 64'(out_valid_b), 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("b_out_valid", 64'(out_valid_b), 64'd1);
      chk("b_out_row", out_row_b, blk[i] ^ Ones);
      step();
    end
    chk("b_in_ready_end", 64'(in_ready_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached before the summary line");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/whirlpool_round_sequencer.md
WHIRLPOOL_ROUND_SEQUENCER -- requirements
Module: whirlpool_round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 10: number of round-enable cycles issued per block; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; the block SHALL use one clock, with reset synchronous and active-high.
REQ-004 in_valid  input  1  a row is offered on in_row.
REQ-005 in_ready  output  1  the sequencer accepts a row this cycle.
REQ-006 in_row  input  64  one state-matrix row; bits [63:56] = column 0 byte ... [7:0] = column 7 byte.
REQ-007 dp_block  output  512 ([0:511])  assembled state to the round datapath; row r, column c byte SHALL occupy bits [64r+8c : 64r+8c+7].
REQ-008 dp_load  output  1  one-cycle pulse: the datapath loads dp_block.
REQ-009 dp_round_en  output  1  the datapath executes one round this cycle.
REQ-010 dp_round_idx  output  4  round number 1..ROUNDS while dp_round_en=1; 0 otherwise.
REQ-011 dp_result  input  512 ([0:511])  datapath state, same byte mapping as dp_block.
REQ-012 out_valid  output  1  a result row is presented.
REQ-013 out_ready  input  1  downstream accepts the row.
REQ-014 out_row  output  64  result row, same byte order as in_row.
REQ-015 busy  output  1  high in every state except COLLECT.

Function
REQ-016 States SHALL be COLLECT, LOAD, ROUND, CAPTURE and DRAIN; the encoding is free.
REQ-017 COLLECT: in_ready=1; each in_valid&in_ready cycle SHALL write in_row into row slot row_cnt (3-bit) and increment row_cnt.
REQ-018 COLLECT: the handshake with row_cnt=7 SHALL wrap row_cnt to 0 and move to LOAD.
REQ-019 in_ready SHALL be 0 in all states other than COLLECT; in_valid in those states SHALL be ignored, with no slot write.
REQ-020 LOAD: dp_load=1 for exactly one cycle, round_cnt set to 1, then ROUND.
REQ-021 ROUND: dp_round_en=1 and dp_round_idx=round_cnt each cycle; round_cnt increments; after the cycle with round_cnt=ROUNDS, move to CAPTURE. Exactly ROUNDS consecutive enable cycles SHALL occur.
REQ-022 CAPTURE: one cycle; dp_result SHALL be registered into the 512-bit output buffer; then DRAIN.
REQ-023 DRAIN: out_valid=1 and out_row = output-buffer row out_cnt (3-bit).
REQ-024 DRAIN: each out_valid&out_ready handshake increments out_cnt.
REQ-025 DRAIN: the handshake with out_cnt=7 SHALL wrap out_cnt to 0 and return to COLLECT.
REQ-026 While out_ready=0, out_valid and out_row SHALL hold stable; there is no timeout.
REQ-027 dp_block SHALL be driven directly from the row slots and SHALL remain stable from LOAD through CAPTURE.
REQ-028 Latency: with the 8th input handshake in cycle T:
  - dp_load=1 in T+1
  - dp_round_en=1 in T+2..T+1+ROUNDS
  - CAPTURE in T+2+ROUNDS
  - first out_valid in T+3+ROUNDS (T+13 at default)
REQ-029 dp_load and dp_round_en SHALL never be high in the same cycle.
REQ-030 No new input SHALL be accepted until the 8th output row has been handshaked; the first possible in_ready is the cycle after that handshake.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter COLLECT with row_cnt=0, out_cnt=0 and round_cnt=0, regardless of the current state, including mid-collect, mid-round and mid-drain.
REQ-032 During and after reset, outputs SHALL be: in_ready=1, out_valid=0, dp_load=0, dp_round_en=0, dp_round_idx=0, busy=0.
REQ-033 Row slots and the output buffer SHALL reset to zero, so dp_block=0 and out_row=0 after reset.
REQ-034 A partially collected block is discarded on reset and SHALL never be issued.

Verification
REQ-035 Basic flow: rows 0x0001020304050607 + 0x0808080808080808*r for r=0..7, with out_ready=1 and a datapath model that XORs 0xFF per round. Required response:
  - dp_block bits [0:7]=0x00 and [504:511]=0x3F
  - dp_load at T+1; dp_round_idx sequence 1..10
  - out_valid at T+13
  - out_row row 0 = dp_result row 0 as captured at T+12
REQ-036 Backpressure: out_ready=0 for 5 cycles at out_cnt=3 -> out_row constant at row 3, out_valid=1 throughout, rows 4..7 follow once ready returns.
REQ-037 Input gaps and blocking: in_valid toggling 1/0 -> exactly 8 slot writes, no slot skipped; in_valid=1 held during ROUND -> in_ready=0 and no slot change.
REQ-038 Mid-round reset: rst pulse at dp_round_idx=4 -> next cycle COLLECT, all outputs at reset values; a following full block completes with a fresh idx 1..10.
REQ-039 ROUNDS=1 build -> single dp_round_en cycle with idx 1; out_valid at T+4.
REQ-040 Back-to-back: 8th output handshake and in_valid=1 in the same cycle -> input is not accepted that cycle; it is accepted in the next cycle into slot 0.
